// File: rtl/music_pkg.sv
// Shared definitions for the music core: opcode constants, timing defaults and
// the prefetch FSM state type. Used by ins_prefetch and the execute stage.
package music_pkg;

    localparam logic [3:0]  OP_END          = 4'b0000;
    localparam logic [3:0]  OP_BPM          = 4'b0001;
    localparam int          NOTE_BIT        = 15;
    localparam logic [15:0] PLACEHOLDER_INS = 16'h8001;
    localparam int          CYCLES_PER_SEC  = 50_000_000;
    localparam int          DEFAULT_BPM     = 96;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_ADDR,
        FS_WAIT,
        FS_CAPTURE,
        FS_STALL,
        FS_HALT
    } fetchState_t;

    function automatic logic isEndOp(input logic [3:0] opcode);
        return opcode == OP_END;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Small first-word-fall-through queue. The head entry is always visible on
// headData; count reports occupancy. Pop of an empty queue is ignored, and a
// push into a full queue is accepted only when a pop frees the slot in the
// same cycle. flush empties the queue without touching stored words.
module ins_fifo #(
    parameter int              DEPTH      = 4,
    parameter int              WIDTH      = 34,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         headData,
    output logic                     notEmpty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPop;
    logic             doPush;

    assign doPop    = pop && (count != '0);
    assign doPush   = push && ((count != CW'(DEPTH)) || doPop);
    assign headData = mem[rdPtr];
    assign notEmpty = (count != '0);

    // Storage, pointers and occupancy; entries reset so the head shows a known word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_WORD;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PW'(1);
            end
            if (doPop) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetch for the music core: walks song memory in SRAM, waits
// out the read latency, and queues words with their addresses for execute.
// Optional build macro: INS_PREFETCH_LOOP_EN (END restarts from start_addr
// instead of halting; END word is not queued and done never asserts).
//
// state   | meaning
// IDLE    | after reset, waiting for start
// ADDR    | drive SRAM_A with pc, clear wait counter
// WAIT    | let SRAM read data settle
// CAPTURE | sample SRAM_D, queue word, advance pc
// STALL   | queue full, wait for a pop before next read
// HALT    | END fetched, waiting for start
module ins_prefetch #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [DATA_W-1:0] SRAM_D,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              busy,
    output logic              done
);
    import music_pkg::*;

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = $clog2(WAIT_CYC) + 1;

    fetchState_t               state;
    fetchState_t               stateNext;
    logic [ADDR_W-1:0]         pc;
    logic [WCW-1:0]            wcnt;
    logic [CW-1:0]             fifoCount;
    logic                      fifoPush;
    logic                      fifoFlush;
    logic                      popFire;
    logic                      wordIsEnd;
    logic                      waitDone;
    logic [CW:0]               occKeep;
    logic [CW:0]               occPush;
    logic                      canIssueKeep;
    logic                      canIssuePush;
    logic [ADDR_W+DATA_W-1:0]  headWord;
`ifdef INS_PREFETCH_LOOP_EN
    logic [ADDR_W-1:0]         startAddrQ;
`endif

    // Occupancy after this cycle's pop, with and without the word being captured.
    assign popFire      = ins_valid && ins_ready;
    assign occKeep      = {1'b0, fifoCount} - (CW+1)'(popFire);
    assign occPush      = occKeep + (CW+1)'(1);
    assign canIssueKeep = occKeep < (CW+1)'(DEPTH);
    assign canIssuePush = occPush < (CW+1)'(DEPTH);
    assign wordIsEnd    = isEndOp(SRAM_D[DATA_W-1 -: 4]);
    assign waitDone     = (wcnt == WCW'(WAIT_CYC - 1));

    assign ins_pc   = headWord[DATA_W +: ADDR_W];
    assign ins_data = headWord[DATA_W-1:0];

    ins_fifo #(
        .DEPTH      (DEPTH),
        .WIDTH      (ADDR_W + DATA_W),
        .RESET_WORD ({ADDR_W'(0), DATA_W'(PLACEHOLDER_INS)})
    ) queue (
        .CLK      (CLK),
        .RST      (RST),
        .push     (fifoPush),
        .pushData ({pc, SRAM_D}),
        .pop      (ins_ready),
        .flush    (fifoFlush),
        .headData (headWord),
        .notEmpty (ins_valid),
        .count    (fifoCount)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= FS_IDLE;
        else     state <= stateNext;
    end

    // Next-state: a new read is only issued when the queue will have room for it.
    always_comb begin
        stateNext = state;
        case (state)
            FS_IDLE, FS_HALT: if (start) stateNext = FS_ADDR;
            FS_ADDR:          stateNext = FS_WAIT;
            FS_WAIT:          if (waitDone) stateNext = FS_CAPTURE;
            FS_CAPTURE: begin
`ifdef INS_PREFETCH_LOOP_EN
                if (wordIsEnd) stateNext = canIssueKeep ? FS_ADDR : FS_STALL;
                else           stateNext = canIssuePush ? FS_ADDR : FS_STALL;
`else
                if (wordIsEnd) stateNext = FS_HALT;
                else           stateNext = canIssuePush ? FS_ADDR : FS_STALL;
`endif
            end
            FS_STALL:         if (canIssueKeep) stateNext = FS_ADDR;
            default:          stateNext = FS_IDLE;
        endcase
    end

    // FSM outputs: status and queue control.
    always_comb begin
        busy      = (state != FS_IDLE) && (state != FS_HALT);
`ifdef INS_PREFETCH_LOOP_EN
        fifoPush  = (state == FS_CAPTURE) && !wordIsEnd;
`else
        fifoPush  = (state == FS_CAPTURE);
`endif
        fifoFlush = (state == FS_HALT) && start;
    end

    // Address walk, latency counter and done flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= '0;
            SRAM_A <= '0;
            wcnt   <= '0;
            done   <= 1'b0;
`ifdef INS_PREFETCH_LOOP_EN
            startAddrQ <= '0;
`endif
        end else begin
            case (state)
                FS_IDLE, FS_HALT: begin
                    if (start) begin
                        pc   <= start_addr;
                        done <= 1'b0;
`ifdef INS_PREFETCH_LOOP_EN
                        startAddrQ <= start_addr;
`endif
                    end
                end
                FS_ADDR: begin
                    SRAM_A <= pc;
                    wcnt   <= '0;
                end
                FS_WAIT: wcnt <= wcnt + WCW'(1);
                FS_CAPTURE: begin
`ifdef INS_PREFETCH_LOOP_EN
                    if (wordIsEnd) pc <= startAddrQ;
                    else           pc <= pc + ADDR_W'(1);
`else
                    pc <= pc + ADDR_W'(1);
                    if (wordIsEnd) done <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_prefetch.sv
// Scoreboard bench for ins_prefetch. The reference model walks a behavioural
// SRAM image from the start address until END and queues the expected
// (address, word) stream; a monitor compares every consumed head word.
module tb_ins_prefetch;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 4;
    localparam int WAIT_CYC = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] SRAM_A;
    logic [DATA_W-1:0] SRAM_D;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_valid;
    logic              ins_ready;
    logic              busy;
    logic              done;

    ins_prefetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr),
        .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .ins_data(ins_data), .ins_pc(ins_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .busy(busy), .done(done)
    );

    always #10 CLK = ~CLK;

    int          nPass  = 0;
    int          nTotal = 0;
    logic [33:0] sbQ[$];
    logic [15:0] sram [0:262143];
    logic [15:0] d1, d2;
    logic        randMode   = 1'b0;
    logic        readyForce = 1'b0;
    logic        holdPrev   = 1'b0;
    logic [33:0] heldWord   = '0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // SRAM: data for an address becomes visible WAIT_CYC+1 edges after it is driven.
    initial begin
        SRAM_D = '0; d1 = '0; d2 = '0;
        forever begin
            @(posedge CLK); #1;
            SRAM_D = d2;
            d2     = d1;
            d1     = sram[SRAM_A];
        end
    end

    initial begin
        ins_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            ins_ready = randMode ? ($urandom_range(0, 3) != 0) : readyForce;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            holdPrev = 1'b0;
        end else begin
            if (holdPrev) begin
                check("hold_valid", 34'(ins_valid), 34'(1));
                check("hold_word", {ins_pc, ins_data}, heldWord);
            end
            if (ins_valid && ins_ready) begin
                if (sbQ.size() == 0) begin
                    nTotal++;
                    $display("FAIL unexpected_word: got %h expected none", {ins_pc, ins_data});
                end else begin
                    check("word", {ins_pc, ins_data}, sbQ.pop_front());
                end
            end
            holdPrev = ins_valid && !ins_ready && !start;
            heldWord = {ins_pc, ins_data};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic loadSong(input logic [17:0] sa, input int len);
        logic [17:0] a = sa;
        for (int i = 0; i < len - 1; i++) begin
            sram[a] = {4'($urandom_range(1, 15)), 12'($urandom)};
            a = a + 18'd1;
        end
        sram[a] = 16'h0000;
    endtask

    // Reference model: every word from sa up to and including END, in order.
    task automatic pushExpected(input logic [17:0] sa);
        logic [17:0] a = sa;
        for (int n = 0; n < 4096; n++) begin
            sbQ.push_back({a, sram[a]});
            if (sram[a][15:12] == 4'b0000) break;
            a = a + 18'd1;
        end
    endtask

    task automatic doStart(input logic [17:0] sa, input bit expectRun);
        start_addr = sa;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        if (expectRun) begin
            sbQ.delete();
            pushExpected(sa);
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin tick(1); n++; end
        check(name, 34'(done), 34'(1));
    endtask

    task automatic drain(input string name);
        int n = 0;
        randMode = 1'b0;
        readyForce = 1'b1;
        tick(1);
        while (ins_valid && n < 300) begin tick(1); n++; end
        check({name, "_drained"}, 34'(ins_valid), 34'(0));
        check({name, "_sb_empty"}, 34'(sbQ.size()), 34'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 262144; i++) sram[i] = 16'hF0F0;
        RST = 1'b1; start = 1'b0; start_addr = '0;
        tick(3);
        check("rst_sram_a", 34'(SRAM_A), 34'(0));
        check("rst_ins_data", 34'(ins_data), 34'(16'h8001));
        check("rst_ins_pc", 34'(ins_pc), 34'(0));
        check("rst_valid", 34'(ins_valid), 34'(0));
        check("rst_busy", 34'(busy), 34'(0));
        check("rst_done", 34'(done), 34'(0));
        RST = 1'b0;
        tick(2);

`ifdef INS_PREFETCH_LOOP_EN
        sram[0] = 16'h8001; sram[1] = 16'h0000;
        readyForce = 1'b1;
        tick(1);
        start_addr = '0; start = 1'b1; tick(1); start = 1'b0;
        sbQ.delete();
        for (int i = 0; i < 200; i++) sbQ.push_back({18'h0, 16'h8001});
        n = 0;
        while (sbQ.size() > 180 && n < 600) begin tick(1); n++; end
        check("loop_progress", 34'(sbQ.size() <= 180), 34'(1));
        check("loop_done_low", 34'(done), 34'(0));
        check("loop_busy", 34'(busy), 34'(1));
        readyForce = 1'b0;
        tick(3);
        RST = 1'b1; sbQ.delete(); tick(1); RST = 1'b0; tick(1);
`else
        // Four-word song, execute always ready; check first-word latency.
        sram[18'h10] = 16'h8001; sram[18'h11] = 16'h1060;
        sram[18'h12] = 16'h8123; sram[18'h13] = 16'h0000;
        readyForce = 1'b1;
        tick(1);
        doStart(18'h10, 1'b1);
        n = 0;
        while (!ins_valid && n < 20) begin tick(1); n++; end
        check("first_valid_latency", 34'(n), 34'(WAIT_CYC + 2));
        waitDone("t1_done", 100);
        drain("t1");
        check("t1_sram_a_frozen", 34'(SRAM_A), 34'(18'h13));
        check("t1_busy", 34'(busy), 34'(0));

        // Execute stalled: queue fills to DEPTH and reads stop.
        loadSong(18'h100, 10);
        readyForce = 1'b0;
        tick(1);
        doStart(18'h100, 1'b1);
        tick(40);
        check("t2_sram_a_stall", 34'(SRAM_A), 34'(18'h100 + DEPTH - 1));
        check("t2_valid", 34'(ins_valid), 34'(1));
        check("t2_busy", 34'(busy), 34'(1));
        tick(20);
        check("t2_sram_a_still", 34'(SRAM_A), 34'(18'h100 + DEPTH - 1));
        readyForce = 1'b1;
        waitDone("t2_done", 200);
        drain("t2");

        // Address wrap at the top of SRAM.
        sram[18'h3FFFF] = 16'h8001; sram[18'h0] = 16'h0000;
        randMode = 1'b1;
        doStart(18'h3FFFF, 1'b1);
        waitDone("t3_done", 100);
        drain("t3");

        // Reset while the third word is in flight, then restart.
        loadSong(18'h20, 6);
        doStart(18'h20, 1'b1);
        n = 0;
        while (SRAM_A != 18'h22 && n < 60) begin tick(1); n++; end
        check("t4_reach_third", 34'(SRAM_A), 34'(18'h22));
        RST = 1'b1; sbQ.delete(); #1;
        check("t4_rst_valid", 34'(ins_valid), 34'(0));
        check("t4_rst_busy", 34'(busy), 34'(0));
        check("t4_rst_sram_a", 34'(SRAM_A), 34'(0));
        tick(2); RST = 1'b0; tick(1);
        doStart(18'h20, 1'b1);
        waitDone("t4_done", 200);
        drain("t4");

        // start while busy is ignored; start in HALT flushes stale words.
        loadSong(18'h200, 3);
        loadSong(18'h300, 5);
        readyForce = 1'b0;
        tick(1);
        doStart(18'h200, 1'b1);
        tick(3);
        check("t6_busy", 34'(busy), 34'(1));
        doStart(18'h300, 1'b0);
        waitDone("t6_done_a", 100);
        check("t6_head_a", {ins_pc, ins_data}, {18'h200, sram[18'h200]});
        doStart(18'h300, 1'b1);
        check("t6_flushed", 34'(ins_valid), 34'(0));
        check("t6_done_cleared", 34'(done), 34'(0));
        randMode = 1'b1;
        waitDone("t6_done_b", 200);
        drain("t6");

        // Random songs, random start addresses, random backpressure.
        for (int r = 0; r < 8; r++) begin
            logic [17:0] sa;
            sa = 18'($urandom_range(0, 262143));
            loadSong(sa, $urandom_range(1, 12));
            randMode = 1'b1;
            doStart(sa, 1'b1);
            waitDone("rand_done", 400);
            drain("rand");
        end
`endif

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
